// File: rtl/dmx_pkg.sv
// Shared types and constants for the DMX512 receiver slice.
package dmx_pkg;

  localparam int DMX_CLK_HZ     = 12_000_000;
  localparam int DMX_BAUD       = 250_000;
  localparam int DMX_BREAK_CLKS = 1056;
  localparam int DMX_MAX_SLOTS  = 512;
  localparam int SLOT_W         = 10;

  typedef logic [SLOT_W-1:0] slot_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BREAK,
    ST_WAIT_START,
    ST_START,
    ST_DATA,
    ST_STOP
  } dmx_state_e;

  // Fabric clocks per DMX bit (48 at 12 MHz / 250 kbaud).
  function automatic int bit_clks(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/dmx_rx_if.sv
// Slot/frame output bundle from the DMX receiver to the patch logic.
interface dmx_rx_if;

  logic [7:0]        slot_data;
  dmx_pkg::slot_idx_t slot_index;
  logic              slot_valid;
  logic              frame_start;
  dmx_pkg::slot_idx_t frame_slots;
  logic              frame_end;
  logic              framing_error;
  logic              overflow;

  modport master (
    output slot_data, slot_index, slot_valid, frame_start,
           frame_slots, frame_end, framing_error, overflow
  );

  modport slave (
    input  slot_data, slot_index, slot_valid, frame_start,
           frame_slots, frame_end, framing_error, overflow
  );

endinterface

// File: rtl/dmx_rx_sync.sv
// Receive-line synchroniser with falling-edge detect.
// DMX_RX_GLITCH_FILTER_EN: adds a 3-sample majority filter (+1 cycle) so
// single-cycle pulses never reach the receiver FSM.
module dmx_rx_sync (
  input  logic CLK12,
  input  logic RST,
  input  logic DMX_RX,
  output logic rx_s,
  output logic rx_fall
);

  logic meta, sync, rx_prev;

  // Two-flop synchroniser; resets to mark so no phantom low is counted.
  always_ff @(posedge CLK12) begin
    if (RST) begin
      meta <= 1'b1;
      sync <= 1'b1;
    end else begin
      meta <= DMX_RX;
      sync <= meta;
    end
  end

`ifdef DMX_RX_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic       filt;

  // Majority of the current and two previous synchronised samples.
  always_ff @(posedge CLK12) begin
    if (RST) begin
      hist <= 2'b11;
      filt <= 1'b1;
    end else begin
      hist <= {hist[0], sync};
      filt <= (sync & hist[0]) | (sync & hist[1]) | (hist[0] & hist[1]);
    end
  end

  assign rx_s = filt;
`else
  assign rx_s = sync;
`endif

  // Previous sample for the falling-edge detector.
  always_ff @(posedge CLK12) begin
    if (RST) rx_prev <= 1'b1;
    else     rx_prev <= rx_s;
  end

  assign rx_fall = rx_prev & ~rx_s;

endmodule

// File: rtl/dmx_rx.sv
// DMX512 receiver: break / MAB / 8N2 slot recovery on the 12 MHz fabric.
// Optional DMX_RX_GLITCH_FILTER_EN enables the majority filter in dmx_rx_sync.
module dmx_rx import dmx_pkg::*; #(
  parameter int CLK_HZ     = DMX_CLK_HZ,
  parameter int BAUD       = DMX_BAUD,
  parameter int BREAK_CLKS = DMX_BREAK_CLKS,
  parameter int MAX_SLOTS  = DMX_MAX_SLOTS
) (
  input  logic       CLK12,
  input  logic       RST,
  input  logic       DMX_RX,
  dmx_rx_if.master   bus
);

  localparam int BIT_CLKS = bit_clks(CLK_HZ, BAUD);
  localparam int BRK_W    = $clog2(BREAK_CLKS + 1);
  localparam int CLK_W    = $clog2(BIT_CLKS + 1);

  localparam logic [BRK_W-1:0] BRK_LAST  = BRK_W'(BREAK_CLKS - 1);
  localparam logic [BRK_W-1:0] BRK_MAX   = BRK_W'(BREAK_CLKS);
  localparam logic [CLK_W-1:0] HALF_LAST = CLK_W'(BIT_CLKS / 2 - 1);
  localparam logic [CLK_W-1:0] BIT_LAST  = CLK_W'(BIT_CLKS - 1);
  // Counter ceiling: one past the last accepted slot marks overflow.
  localparam slot_idx_t        SLOT_LIM  = slot_idx_t'(MAX_SLOTS + 1);

  logic             rx_s, rx_fall;
  dmx_state_e       state, state_nxt;
  logic [BRK_W-1:0] brk_cnt;
  logic [CLK_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  slot_idx_t        slot_cnt;
  logic             brk_hit, tick_half, tick_bit;
  logic             do_fstart, do_fend, do_accept, do_ferr;

  dmx_rx_sync u_sync (
    .CLK12   (CLK12),
    .RST     (RST),
    .DMX_RX  (DMX_RX),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  // A break is recognised on the exact cycle the low run reaches BREAK_CLKS;
  // saturation keeps it from re-firing during a long break.
  assign brk_hit   = ~rx_s && (brk_cnt == BRK_LAST);
  assign tick_half = (clk_cnt == HALF_LAST);
  assign tick_bit  = (clk_cnt == BIT_LAST);

  // Consecutive-low counter, runs in every state.
  always_ff @(posedge CLK12) begin
    if (RST)                   brk_cnt <= '0;
    else if (rx_s)             brk_cnt <= '0;
    else if (brk_cnt != BRK_MAX) brk_cnt <= brk_cnt + 1'b1;
  end

  // State register.
  always_ff @(posedge CLK12) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state; a recognised break overrides everything, including STOP.
  always_comb begin
    state_nxt = state;
    if (brk_hit) state_nxt = ST_BREAK;
    else begin
      case (state)
        ST_IDLE:       state_nxt = ST_IDLE;
        ST_BREAK:      if (rx_s)      state_nxt = ST_WAIT_START;
        ST_WAIT_START: if (rx_fall)   state_nxt = ST_START;
        ST_START:      if (tick_half) state_nxt = rx_s ? ST_WAIT_START : ST_DATA;
        ST_DATA:       if (tick_bit && bit_idx == 3'd7) state_nxt = ST_STOP;
        ST_STOP:       if (tick_bit)  state_nxt = ST_WAIT_START;
        default:       state_nxt = ST_IDLE;
      endcase
    end
  end

  // One-cycle events decoded from state and line.
  always_comb begin
    do_fstart = 1'b0;
    do_fend   = 1'b0;
    do_accept = 1'b0;
    do_ferr   = 1'b0;
    if (brk_hit) begin
      do_fend = (slot_cnt != '0);
    end else begin
      if (state == ST_BREAK && rx_s) do_fstart = 1'b1;
      if (state == ST_STOP && tick_bit) begin
        do_accept = rx_s;
        do_ferr   = ~rx_s;
      end
    end
  end

  // Bit timing, shift register and slot counter.
  always_ff @(posedge CLK12) begin
    if (RST) begin
      clk_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      slot_cnt <= '0;
    end else begin
      clk_cnt <= clk_cnt + 1'b1;
      case (state)
        ST_WAIT_START: begin
          clk_cnt <= '0;
          bit_idx <= '0;
        end
        ST_START: if (tick_half) clk_cnt <= '0;
        ST_DATA: if (tick_bit) begin
          clk_cnt <= '0;
          shreg   <= {rx_s, shreg[7:1]};
          bit_idx <= bit_idx + 1'b1;
        end
        ST_STOP: if (tick_bit) clk_cnt <= '0;
        default: clk_cnt <= '0;
      endcase
      if (do_fstart)                            slot_cnt <= '0;
      else if (do_accept && slot_cnt != SLOT_LIM) slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Registered outputs; slot strobe lands the cycle after the stop sample.
  always_ff @(posedge CLK12) begin
    if (RST) begin
      bus.slot_data     <= '0;
      bus.slot_index    <= '0;
      bus.slot_valid    <= 1'b0;
      bus.frame_start   <= 1'b0;
      bus.frame_slots   <= '0;
      bus.frame_end     <= 1'b0;
      bus.framing_error <= 1'b0;
      bus.overflow      <= 1'b0;
    end else begin
      bus.slot_valid    <= do_accept && (slot_cnt != SLOT_LIM);
      bus.frame_start   <= do_fstart;
      bus.frame_end     <= do_fend;
      bus.framing_error <= do_ferr;
      if (do_accept && slot_cnt != SLOT_LIM) begin
        bus.slot_data  <= shreg;
        bus.slot_index <= slot_cnt;
      end
      if (do_fend) bus.frame_slots <= slot_cnt;
      if (do_fstart)                               bus.overflow <= 1'b0;
      else if (do_accept && slot_cnt == SLOT_LIM)  bus.overflow <= 1'b1;
    end
  end

endmodule
